// File: rtl/rsa_pkg.sv
// Shared encodings and reset defaults for the RSA modular exponentiation engine.
// Optional constant-time iteration is selected with RSA_CONST_TIME_EN (see rsa_modexp_engine).
package rsa_pkg;

  typedef enum logic [1:0] {
    LD_NONE = 2'd0,
    LD_MSG  = 2'd1,
    LD_EXP  = 2'd2,
    LD_MOD  = 2'd3
  } load_type_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    MUL    = 3'd2,
    SQR    = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_E = 7;
  localparam int unsigned DEFAULT_N = 143;

endpackage

// File: rtl/rsa_mulmod.sv
// Iterative MSB-first shift-add modular multiplier: r = (a * b) mod n in WIDTH+1 cycles.
// Requires a < n; b may be any WIDTH-bit value.
module rsa_mulmod #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH+1:0] acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [WIDTH+1:0] n_ext;
  logic [WIDTH+1:0] step_sum;
  logic [WIDTH+1:0] sub1;
  logic [WIDTH+1:0] acc_next;

  // acc < n keeps 2*acc + a below 3n, so two conditional subtractions suffice.
  always_comb begin
    n_ext    = {2'b00, n_q};
    step_sum = {acc_q[WIDTH:0], 1'b0} + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    sub1     = (step_sum >= n_ext) ? (step_sum - n_ext) : step_sum;
    acc_next = (sub1 >= n_ext) ? (sub1 - n_ext) : sub1;
  end

  // start is a single-cycle launch; done flags the final step, and r is valid only while done is high.
  assign done = run_q && (cnt_q == CW'(1));
  assign r    = acc_next[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      acc_q <= '0;
      a_q   <= a;
      b_q   <= b;
      n_q   <= n;
      cnt_q <= CW'(WIDTH);
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_next;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_modexp_engine.sv
// Right-to-left square-and-multiply m^e mod n over a WIDTH-bit exponent, operands loaded by type.
// Define RSA_CONST_TIME_EN to always process all exponent bits with a dummy multiply on zero bits.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int             WIDTH     = 16,
  parameter logic [WIDTH-1:0] DEFAULT_E = WIDTH'(rsa_pkg::DEFAULT_E),
  parameter logic [WIDTH-1:0] DEFAULT_N = WIDTH'(rsa_pkg::DEFAULT_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       load_type,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);

`ifdef RSA_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  localparam int IW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    i_q, i_d;
  logic             launched_q, launched_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             err_pend_q, err_pend_d;

  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_done;
  logic [WIDTH-1:0] mul_r;

  logic [IW-1:0]    i_next;
  logic             cur_bit;
  logic             next_bit;
  logic             tail_zero;

  rsa_mulmod #(.WIDTH(WIDTH)) u_mulmod (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .n     (n_q),
    .done  (mul_done),
    .r     (mul_r)
  );

  always_comb begin
    i_next    = i_q + IW'(1);
    cur_bit   = |(e_q & (WIDTH'(1) << i_q));
    next_bit  = |(e_q & (WIDTH'(1) << i_next));
    tail_zero = ((e_q >> i_next) == '0);
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    e_d        = e_q;
    n_d        = n_q;
    acc_d      = acc_q;
    base_d     = base_q;
    result_d   = result_q;
    i_d        = i_q;
    launched_d = launched_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_pend_d = err_pend_q;
    mul_start  = 1'b0;
    mul_a      = acc_q;
    mul_b      = base_q;

    case (state_q)
      IDLE: begin
        if (load_type == LD_EXP) e_d = data_in;
        if (load_type == LD_MOD) n_d = data_in;
        if (load_type == LD_MSG) begin
          m_d     = data_in;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          if (n_q < WIDTH'(2)) begin
            err_pend_d = 1'b1;
            state_d    = FIN;
          end else begin
            err_pend_d = 1'b0;
            acc_d      = WIDTH'(1);
            i_d        = '0;
            state_d    = REDUCE;
          end
        end
      end

      // Multiplying by 1 with m on the unconstrained b side folds any m >= n into range.
      REDUCE: begin
        mul_a = WIDTH'(1);
        mul_b = m_q;
        if (!launched_q) begin
          mul_start  = 1'b1;
          launched_d = 1'b1;
        end else if (mul_done) begin
          launched_d = 1'b0;
          base_d     = mul_r;
          state_d    = (CONST_TIME || cur_bit) ? MUL : SQR;
        end
      end

      MUL: begin
        mul_a = acc_q;
        mul_b = base_q;
        if (!launched_q) begin
          mul_start  = 1'b1;
          launched_d = 1'b1;
        end else if (mul_done) begin
          launched_d = 1'b0;
          if (cur_bit) acc_d = mul_r;
          state_d = SQR;
        end
      end

      SQR: begin
        mul_a = base_q;
        mul_b = base_q;
        if (!launched_q) begin
          mul_start  = 1'b1;
          launched_d = 1'b1;
        end else if (mul_done) begin
          launched_d = 1'b0;
          base_d     = mul_r;
          i_d        = i_next;
          if ((i_next == IW'(WIDTH)) || (!CONST_TIME && tail_zero)) state_d = FIN;
          else if (CONST_TIME || next_bit) state_d = MUL;
          else state_d = SQR;
        end
      end

      FIN: begin
        result_d = err_pend_q ? '0 : acc_q;
        error_d  = err_pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      e_q        <= DEFAULT_E;
      n_q        <= DEFAULT_N;
      acc_q      <= '0;
      base_q     <= '0;
      result_q   <= '0;
      i_q        <= '0;
      launched_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      e_q        <= e_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      result_q   <= result_d;
      i_q        <= i_d;
      launched_q <= launched_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed and randomized checks of rsa_modexp_engine against a plain-arithmetic modexp model.
// Latency expectations follow RSA_CONST_TIME_EN when the bench is built with it.
module tb_rsa_modexp_engine;
  import rsa_pkg::*;

  localparam int WIDTH  = 16;
  localparam int CT_LAT = (1 + 2 * WIDTH) * (WIDTH + 1) + 1;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       load_type;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_e;
  logic [WIDTH-1:0] model_n;

  always #5 clk = ~clk;

  rsa_modexp_engine #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .load_type (load_type),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .result    (result)
  );

  function automatic logic [WIDTH-1:0] ref_modexp(input logic [WIDTH-1:0] m,
                                                   input logic [WIDTH-1:0] e,
                                                   input logic [WIDTH-1:0] n);
    longint unsigned r, b;
    if (n < 2) return '0;
    r = 1;
    b = longint'(m) % longint'(n);
    for (int k = 0; k < WIDTH; k++) begin
      if (e[k]) r = (r * b) % longint'(n);
      b = (b * b) % longint'(n);
    end
    return WIDTH'(r);
  endfunction

  // Cycles from the start-capture edge to the edge that raises done.
  function automatic int ref_latency(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] n);
    int top, ops;
    if (n < 2) return 1;
`ifdef RSA_CONST_TIME_EN
    return CT_LAT;
`else
    top = 0;
    for (int k = 0; k < WIDTH; k++) if (e[k]) top = k + 1;
    if (top == 0) top = 1;
    ops = 1 + top;
    for (int k = 0; k < top; k++) if (e[k]) ops++;
    return ops * (WIDTH + 1) + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] lt, input logic [WIDTH-1:0] d);
    @(negedge clk);
    load_type = lt;
    data_in   = d;
    @(negedge clk);
    load_type = LD_NONE;
  endtask

  task automatic load_exp(input logic [WIDTH-1:0] d);
    load(LD_EXP, d);
    model_e = d;
  endtask

  task automatic load_mod(input logic [WIDTH-1:0] d);
    load(LD_MOD, d);
    model_n = d;
  endtask

  // Start a run with message m; optionally poke exponent/start loads while busy.
  task automatic run(input logic [WIDTH-1:0] m, input bit disturb, input string tag);
    int               cyc;
    logic [WIDTH-1:0] exp_r;
    logic             exp_err;
    int               exp_lat;
    exp_r   = ref_modexp(m, model_e, model_n);
    exp_err = (model_n < 2);
    exp_lat = ref_latency(model_e, model_n);
    @(negedge clk);
    load_type = LD_MSG;
    data_in   = m;
    @(posedge clk);
    #1;
    load_type = LD_NONE;
    check($sformatf("%s busy_after_start", tag), busy, 1);
    check($sformatf("%s done_cleared", tag), done, 0);
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
      if (disturb && cyc == 20) begin load_type = LD_EXP; data_in = 5; end
      if (disturb && cyc == 21) begin load_type = LD_MSG; data_in = 3; end
      if (disturb && cyc == 22) load_type = LD_NONE;
    end
    load_type = LD_NONE;
    check($sformatf("%s latency", tag), cyc, exp_lat);
    check($sformatf("%s done", tag), done, 1);
    check($sformatf("%s busy_low", tag), busy, 0);
    check($sformatf("%s error", tag), error, exp_err);
    check($sformatf("%s result", tag), result, exp_r);
  endtask

  initial begin
    logic [WIDTH-1:0] rm;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] rn;

    // Clock/reset
    rst       = 1'b1;
    load_type = LD_NONE;
    data_in   = '0;
    model_e   = 16'd7;
    model_n   = 16'd143;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    // Defaults e=7, n=143
    run(16'd2, 1'b0, "default m=2");
    check("default m=2 const", result, 128);
    run(16'd10, 1'b0, "default m=10");
    check("default m=10 const", result, 10);

    // e=3, n=15
    load_exp(16'd3);
    load_mod(16'd15);
    run(16'd2, 1'b0, "e3n15 m=2");
    check("e3n15 m=2 const", result, 8);
    run(16'd7, 1'b0, "e3n15 m=7");
    check("e3n15 m=7 const", result, 13);
    run(16'd17, 1'b0, "e3n15 m=17");
    check("e3n15 m=17 const", result, 8);

    // Edge cases e=0 and m=0
    load_exp(16'd0);
    run(16'd9, 1'b0, "e0 m=9");
    check("e0 m=9 const", result, 1);
    load_exp(16'd3);
    run(16'd0, 1'b0, "m0 e=3");
    check("m0 e=3 const", result, 0);

    // Degenerate modulus
    load_mod(16'd1);
    run(16'd5, 1'b0, "n1 m=5");
    check("n1 error const", error, 1);
    check("n1 result const", result, 0);
    load_mod(16'd15);

    // Loads while busy are ignored
    run(16'd2, 1'b1, "busy_loads m=2");
    check("busy_loads result const", result, 8);
    run(16'd2, 1'b0, "e_still_3 m=2");
    check("e_still_3 const", result, 8);

`ifdef RSA_CONST_TIME_EN
    load_mod(16'd143);
    load_exp(16'd1);
    run(16'd5, 1'b0, "ct e=1");
    load_exp(16'hFFFF);
    run(16'd5, 1'b0, "ct e=ffff");
`endif

    // Randomized operands
    for (int t = 0; t < 8; t++) begin
      re = (t % 2 == 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom_range(0, 65535));
      rn = WIDTH'($urandom_range(2, 65535));
      rm = WIDTH'($urandom);
      load_exp(re);
      load_mod(rn);
      run(rm, 1'b0, $sformatf("rand%0d", t));
    end

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    load_type = LD_MSG;
    data_in   = 16'd3;
    @(posedge clk);
    #1;
    load_type = LD_NONE;
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset error", error, 0);
    check("midreset result", result, 0);
    @(negedge clk);
    rst     = 1'b0;
    model_e = 16'd7;
    model_n = 16'd143;
    run(16'd2, 1'b0, "after_reset m=2");
    check("after_reset const", result, 128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
